nanci_edge_injector: RTL and testbench
======================================

Name: nanci_edge_injector

Overview:
- Boundary feeder for the Nanci PE mesh.
- Buffers packed {addr,data} words arriving from the host over a valid/ready stream.
- On command, replays the buffer into the neighbouring edge PE's i_PE_l input, one word per HOLD_CYCLES clocks.
- Sits directly upstream of the first-in-row PE.
- Lets a whole row be loaded without a per-cycle host.

Parameters:
- ADDR_WIDTH, 3, address field width of a PE word (upper bits).
- DATA_WIDTH, 3, data field width of a PE word (lower bits).
- DEPTH, 8, buffer capacity in words; must be at least 2.
- HOLD_CYCLES, 1, clocks each word is held on o_PE; matches the PE SORT_CYCLES; must be at least 1.

Ports (W = ADDR_WIDTH+DATA_WIDTH):
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous active-low reset (rst==0 at posedge resets).
- i_valid, input, 1, host word valid.
- i_data, input, W, host word {addr,data}.
- o_ready, output, 1, buffer accepts a word this cycle.
- i_start, input, 1, begin replay (one-cycle pulse or level).
- o_PE, output, W, word driven to the edge PE's i_PE_l.
- o_busy, output, 1, replay in progress.
- o_done, output, 1, one-cycle pulse after the last word finishes.
- o_count, output, clog2(DEPTH+1), words currently buffered.

Behaviour:
- Reset (rst==0 at posedge) forces these values regardless of state, including mid-replay:
  - state=FILL, count=0, rd_ptr=0, hold counter=0.
  - o_PE=0, o_busy=0, o_done=0, o_ready=0.
  - Buffer contents are don't-care.
- o_ready is registered. It equals 1 exactly when state==FILL and count<DEPTH, evaluated for the current cycle.
- FILL state:
  - A word is accepted when i_valid && o_ready at a posedge. It is written to buf[count] and count increments.
  - o_PE=0.
  - When count==DEPTH, o_ready=0 and further i_valid is ignored with no overwrite.
- Start in FILL with count>0:
  - i_start=1 at a posedge goes to STREAM; rd_ptr=0, hold=0.
  - A word offered in the same cycle as i_start is NOT accepted; o_ready drops in that cycle.
- Start in FILL with count==0: i_start is ignored and the block stays in FILL.
- STREAM state:
  - o_PE=buf[rd_ptr] and o_busy=1, both registered.
  - First word appears on o_PE the cycle after the start edge (latency 1).
  - Each word is held exactly HOLD_CYCLES cycles, then rd_ptr increments.
  - After word count-1 completes its hold: next cycle goes to DONE.
  - i_start and i_valid are ignored while in STREAM.
- DONE state, lasting exactly one cycle:
  - o_PE=0, o_busy=0, o_done=1.
  - count clears to 0 and the block returns to FILL.
  - o_ready re-asserts the cycle after DONE.
- Total occupancy of a replay of n words is n*HOLD_CYCLES STREAM cycles plus 1 DONE cycle.
- Word 0 is the idle/null packet, the same as the PE's reset output. Hosts must not rely on a 0 word being distinguishable from idle.
- Widths: no arithmetic on the data itself; only pointer and counter increments, with no wrap beyond DEPTH.

Decomposition:
- Package nanci_pkg holds:
  - the state enum {FILL, STREAM, DONE};
  - a WORD_W localparam function of ADDR_WIDTH+DATA_WIDTH;
  - the null-word constant 0.
- Sub-module nanci_word_buf holds the buffer:
  - DEPTH x W register array, synchronous write and combinational read;
  - no reset on the array.
- FSM, counters and output registers stay in nanci_edge_injector.

Test Plan (W=6, DEPTH=4, HOLD_CYCLES=1 unless stated):
- Fill and replay: load 001000, 010000, 011000, 100000, then pulse i_start.
  - o_PE shows 001000, 010000, 011000, 100000 on consecutive cycles starting one cycle after start.
  - Then 000000 with o_done=1 for exactly one cycle; o_count returns to 0.
- Full buffer: hold i_valid=1 for 6 cycles with values 1..6.
  - o_ready drops after the 4th accept; o_count=4.
  - Replay yields 000001 through 000100 only.
- Hold stretch: HOLD_CYCLES=3, load 2 words 011000 and 100000, then start.
  - 011000 is held 3 cycles, then 100000 is held 3 cycles, then o_done.
  - o_busy is high for exactly 6 cycles.
- Empty start: i_start with count 0 gives no change: o_busy=0, o_PE=000000, o_ready=1.
- Reset mid-replay: drive rst=0 during the 2nd word.
  - Next cycle o_PE=000000, o_busy=0, o_count=0.
  - After rst returns to 1, o_ready=1 and a fresh load/replay works.
- Simultaneous start and valid: i_valid=1 with 011000 in the start cycle.
  - The word is not accepted; replay contains only the previously buffered words.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared types and constants for the Nanci edge injector.
// No timing or flow control of its own; used by the injector and its word buffer.
package nanci_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int word_w(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    // Idle/null packet, identical to a PE's reset output.
    localparam logic [63:0] NULL_WORD = '0;

endpackage

// File: rtl/nanci_word_buf.sv
// DEPTH x W word store: write lands on the clock edge, read is combinational.
// Zero read latency; no flow control here, the caller only writes when it has room.
module nanci_word_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 6,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nanci_edge_injector.sv
// Buffers host words, then replays them into the edge PE one per HOLD_CYCLES clocks.
// First word one cycle after start; o_ready is low while full or replaying.
module nanci_edge_injector
    import nanci_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 3,
    parameter  int DATA_WIDTH  = 3,
    parameter  int DEPTH       = 8,
    parameter  int HOLD_CYCLES = 1,
    localparam int W           = word_w(ADDR_WIDTH, DATA_WIDTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [W-1:0]     i_data,
    output logic             o_ready,
    input  logic             i_start,
    output logic [W-1:0]     o_PE,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [HOLD_W-1:0]  hold;
    logic [PTR_W-1:0]   raddr;
    logic [W-1:0]       rdata;
    logic               start_go;
    logic               accept;
    logic               last_word;
    logic [CNT_W-1:0]   count_next;

    // A start wins over a word offered in the same cycle.
    assign start_go   = (state == FILL) && i_start && (count != '0);
    assign accept     = i_valid && o_ready && !start_go && rst;
    assign count_next = accept ? count + CNT_W'(1) : count;
    assign last_word  = (CNT_W'(rd_ptr) + CNT_W'(1)) == count;

    // Address the word the output register will load on the next edge.
    assign raddr = (state == FILL) ? '0 : rd_ptr + PTR_W'(1);

    nanci_word_buf #(
        .DEPTH (DEPTH),
        .W     (W),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (count[PTR_W-1:0]),
        .wdata (i_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FILL;
            count   <= '0;
            rd_ptr  <= '0;
            hold    <= '0;
            o_PE    <= NULL_WORD[W-1:0];
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (start_go) begin
                        state   <= STREAM;
                        rd_ptr  <= '0;
                        hold    <= '0;
                        o_PE    <= rdata;
                        o_busy  <= 1'b1;
                        o_ready <= 1'b0;
                    end else begin
                        count   <= count_next;
                        o_ready <= count_next < CNT_W'(DEPTH);
                    end
                end
                STREAM: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        if (last_word) begin
                            state  <= DONE;
                            o_PE   <= NULL_WORD[W-1:0];
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                            o_PE   <= rdata;
                        end
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                DONE: begin
                    state   <= FILL;
                    o_done  <= 1'b0;
                    count   <= '0;
                    o_ready <= 1'b1;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign o_count = count;

endmodule

// File: tb/tb_nanci_edge_injector.sv
// Directed bench for nanci_edge_injector: one instance with HOLD_CYCLES=1, one with 3.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_nanci_edge_injector;

    logic       clk = 1'b0;
    logic       rst;

    logic       v1, s1, v3, s3;
    logic [5:0] d1, d3;
    logic       rdy1, busy1, done1, rdy3, busy3, done3;
    logic [5:0] pe1, pe3;
    logic [2:0] cnt1, cnt3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nanci_edge_injector #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(4), .HOLD_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(v1), .i_data(d1), .o_ready(rdy1),
        .i_start(s1), .o_PE(pe1), .o_busy(busy1), .o_done(done1), .o_count(cnt1)
    );

    nanci_edge_injector #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .DEPTH(4), .HOLD_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .i_data(d3), .o_ready(rdy3),
        .i_start(s3), .o_PE(pe3), .o_busy(busy3), .o_done(done3), .o_count(cnt3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load1(input logic [5:0] w);
        v1 = 1'b1;
        d1 = w;
        cyc();
        v1 = 1'b0;
    endtask

    task automatic start1();
        s1 = 1'b1;
        cyc();
        s1 = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        logic [5:0] exp3 [7];
        exp3[0] = 6'o30; exp3[1] = 6'o30; exp3[2] = 6'o30;
        exp3[3] = 6'o40; exp3[4] = 6'o40; exp3[5] = 6'o40;
        exp3[6] = 6'o00;

        rst = 1'b0;
        v1 = 0; s1 = 0; d1 = '0;
        v3 = 0; s3 = 0; d3 = '0;
        cyc();
        cyc();
        chk("rst_ready", 8'(rdy1), 8'd0);
        chk("rst_busy",  8'(busy1), 8'd0);
        chk("rst_done",  8'(done1), 8'd0);
        chk("rst_pe",    8'(pe1), 8'd0);
        chk("rst_count", 8'(cnt1), 8'd0);
        rst = 1'b1;
        cyc();
        chk("ready_after_rst", 8'(rdy1), 8'd1);

        // Fill and replay
        load1(6'o10); load1(6'o20); load1(6'o30); load1(6'o40);
        chk("fill_count", 8'(cnt1), 8'd4);
        chk("fill_ready_full", 8'(rdy1), 8'd0);
        start1();
        chk("rep_w0", 8'(pe1), 8'o10);
        chk("rep_busy", 8'(busy1), 8'd1);
        cyc(); chk("rep_w1", 8'(pe1), 8'o20);
        cyc(); chk("rep_w2", 8'(pe1), 8'o30);
        cyc(); chk("rep_w3", 8'(pe1), 8'o40);
        cyc();
        chk("rep_done_pe", 8'(pe1), 8'd0);
        chk("rep_done", 8'(done1), 8'd1);
        chk("rep_done_busy", 8'(busy1), 8'd0);
        cyc();
        chk("rep_done_clear", 8'(done1), 8'd0);
        chk("rep_count0", 8'(cnt1), 8'd0);
        chk("rep_ready_back", 8'(rdy1), 8'd1);

        // Full buffer: offer 1..6, only 1..4 taken
        v1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            d1 = 6'(i);
            cyc();
            if (i == 4) begin
                chk("full_ready", 8'(rdy1), 8'd0);
                chk("full_count", 8'(cnt1), 8'd4);
            end
        end
        v1 = 1'b0;
        chk("full_count_after", 8'(cnt1), 8'd4);
        start1();
        chk("full_w0", 8'(pe1), 8'd1);
        cyc(); chk("full_w1", 8'(pe1), 8'd2);
        cyc(); chk("full_w2", 8'(pe1), 8'd3);
        cyc(); chk("full_w3", 8'(pe1), 8'd4);
        cyc(); chk("full_done", 8'(done1), 8'd1);
        chk("full_done_pe", 8'(pe1), 8'd0);
        cyc();

        // Empty start is ignored
        start1();
        chk("empty_busy", 8'(busy1), 8'd0);
        chk("empty_pe", 8'(pe1), 8'd0);
        chk("empty_ready", 8'(rdy1), 8'd1);
        cyc();
        chk("empty_busy2", 8'(busy1), 8'd0);
        chk("empty_done", 8'(done1), 8'd0);

        // Start with a word offered in the same cycle
        load1(6'o05); load1(6'o06);
        s1 = 1'b1; v1 = 1'b1; d1 = 6'o30;
        cyc();
        s1 = 1'b0; v1 = 1'b0;
        chk("simul_w0", 8'(pe1), 8'o05);
        chk("simul_count", 8'(cnt1), 8'd2);
        chk("simul_ready", 8'(rdy1), 8'd0);
        cyc(); chk("simul_w1", 8'(pe1), 8'o06);
        cyc();
        chk("simul_done", 8'(done1), 8'd1);
        chk("simul_done_pe", 8'(pe1), 8'd0);
        cyc();

        // Hold stretch on the HOLD_CYCLES=3 instance
        v3 = 1'b1; d3 = 6'o30; cyc();
        d3 = 6'o40; cyc();
        v3 = 1'b0;
        chk("hold_count", 8'(cnt3), 8'd2);
        s3 = 1'b1; cyc(); s3 = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("hold_pe%0d", i), 8'(pe3), 8'(exp3[i]));
            if (busy3) busy_cycles++;
            if (i == 6) chk("hold_done", 8'(done3), 8'd1);
            cyc();
        end
        chk("hold_busy_cycles", 8'(busy_cycles), 8'd6);
        chk("hold_done_clear", 8'(done3), 8'd0);
        chk("hold_ready_back", 8'(rdy3), 8'd1);

        // Reset in the middle of a replay
        load1(6'o10); load1(6'o20); load1(6'o30);
        start1();
        chk("mid_w0", 8'(pe1), 8'o10);
        cyc();
        chk("mid_w1", 8'(pe1), 8'o20);
        rst = 1'b0;
        cyc();
        chk("mid_rst_pe", 8'(pe1), 8'd0);
        chk("mid_rst_busy", 8'(busy1), 8'd0);
        chk("mid_rst_count", 8'(cnt1), 8'd0);
        chk("mid_rst_ready", 8'(rdy1), 8'd0);
        rst = 1'b1;
        cyc();
        chk("mid_ready_back", 8'(rdy1), 8'd1);
        load1(6'o50);
        chk("mid_reload_count", 8'(cnt1), 8'd1);
        start1();
        chk("mid_reload_w0", 8'(pe1), 8'o50);
        cyc();
        chk("mid_reload_done", 8'(done1), 8'd1);
        cyc();
        chk("mid_reload_count0", 8'(cnt1), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
